// File: rtl/cp0_unit.sv
// cp0_unit: a minimal MIPS-style coprocessor 0.
// It holds Count, Compare, Status, Cause and EPC. It decides whether an
// exception or interrupt is taken, and it produces the redirect target for
// exception entry and for ERET.
//
// Ports:
//   i_clk, i_rst      clock; asynchronous active-high reset
//   i_mtc0/i_mfc0     move to / move from CP0 (register number on i_addr)
//   i_eret            return from exception
//   i_unknown_func    reserved instruction
//   i_overflow        signed arithmetic overflow
//   i_wdata, i_pc     MTC0 write data, PC of the current instruction
//   i_int[4:0]        level-sensitive external interrupt lines
//   o_rdata           MFC0 read data (combinational)
//   o_exc_take        exception/interrupt taken this cycle
//   o_eret_take       ERET redirect this cycle
//   o_target          redirect PC (0 when no redirect)
//   o_status/o_cause  current Status / Cause register values
module cp0_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mtc0,
  input  logic        i_mfc0,
  input  logic        i_eret,
  input  logic        i_unknown_func,
  input  logic        i_overflow,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_pc,
  input  logic [4:0]  i_int,
  output logic [31:0] o_rdata,
  output logic        o_exc_take,
  output logic        o_eret_take,
  output logic [31:0] o_target,
  output logic [31:0] o_status,
  output logic [31:0] o_cause
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_epc;
  logic        r_phase;     // Count advances on every second edge
  logic        r_timer;     // Cause.IP[7]
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic [4:0]  r_ip_int;    // one-cycle sample of i_int -> Cause.IP[6:2]
  logic [1:0]  r_ip_sw;     // software interrupt bits, Cause.IP[1:0]
  logic [4:0]  r_exc_code;

  logic [7:0]  w_ip;
  logic        w_irq;
  logic [4:0]  w_exc_code;
  logic        w_wr;
  logic        w_count_load;
  logic        w_compare_wr;
  logic [31:0] w_count_inc;
  logic        w_timer_hit;

  assign w_ip     = {r_timer, r_ip_int, r_ip_sw};
  assign o_status = {16'h0, r_im, 6'h0, r_exl, r_ie};
  assign o_cause  = {16'h0, w_ip, 1'b0, r_exc_code, 2'b00};

  assign w_irq       = (|(w_ip & r_im)) & r_ie & ~r_exl;
  assign o_exc_take  = i_unknown_func | i_overflow | w_irq;
  assign o_eret_take = i_eret & ~o_exc_take;

  // A taken exception squashes the instruction, so its MTC0 has no effect.
  assign w_wr         = i_mtc0 & ~o_exc_take;
  assign w_count_load = w_wr && (i_addr == ADDR_COUNT);
  assign w_compare_wr = w_wr && (i_addr == ADDR_COMPARE);
  assign w_count_inc  = r_count + 32'd1;
  // The timer fires only on a real increment, never on a software load.
  assign w_timer_hit  = r_phase & ~w_count_load & (w_count_inc == r_compare);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    w_exc_code = EXC_INT;
    if (i_unknown_func)  w_exc_code = EXC_RI;
    else if (i_overflow) w_exc_code = EXC_OV;
  end

  always_comb begin
    o_target = 32'h0;
    if (o_exc_take)       o_target = EXC_VECTOR;
    else if (o_eret_take) o_target = r_epc;
  end

  always_comb begin
    o_rdata = 32'h0;
    if (i_mfc0) begin
      case (i_addr)
        ADDR_COUNT:   o_rdata = r_count;
        ADDR_COMPARE: o_rdata = r_compare;
        ADDR_STATUS:  o_rdata = o_status;
        ADDR_CAUSE:   o_rdata = o_cause;
        ADDR_EPC:     o_rdata = r_epc;
        default:      o_rdata = 32'h0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count    <= 32'h0;
      r_compare  <= 32'h0;
      r_epc      <= 32'h0;
      r_phase    <= 1'b0;
      r_timer    <= 1'b0;
      r_im       <= 8'h0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_ip_int   <= 5'h0;
      r_ip_sw    <= 2'h0;
      r_exc_code <= 5'h0;
    end else begin
      r_ip_int <= i_int;

      if (w_count_load) begin
        r_count <= i_wdata;
        r_phase <= 1'b0;
      end else begin
        r_phase <= ~r_phase;
        if (r_phase) r_count <= w_count_inc;
      end

      // A clear from a Compare write wins over a simultaneous timer hit.
      if (w_compare_wr)     r_timer <= 1'b0;
      else if (w_timer_hit) r_timer <= 1'b1;

      if (o_exc_take) begin
        r_exl      <= 1'b1;
        r_exc_code <= w_exc_code;
        // A nested exception keeps the original return address.
        if (!r_exl) r_epc <= i_pc;
      end else begin
        if (w_wr) begin
          case (i_addr)
            ADDR_COMPARE: r_compare <= i_wdata;
            ADDR_STATUS: begin
              r_im  <= i_wdata[15:8];
              r_exl <= i_wdata[1];
              r_ie  <= i_wdata[0];
            end
            ADDR_CAUSE:   r_ip_sw <= i_wdata[9:8];
            ADDR_EPC:     r_epc   <= i_wdata;
            default: ;
          endcase
        end
        if (o_eret_take) r_exl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: a table of single-cycle vectors followed
// by hand-written sequences for the timer, Count wrap and mid-run reset.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mtc0, mfc0, eret, unk, ovf;
  logic [4:0]  addr;
  logic [31:0] wdata, pc;
  logic [4:0]  irq_in;
  logic [31:0] rdata, target, status, cause;
  logic        exc_take, eret_take;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cp0_unit #(.EXC_VECTOR(32'h8000_0180)) dut (
    .i_clk(clk), .i_rst(rst), .i_mtc0(mtc0), .i_mfc0(mfc0), .i_eret(eret),
    .i_unknown_func(unk), .i_overflow(ovf), .i_addr(addr), .i_wdata(wdata),
    .i_pc(pc), .i_int(irq_in), .o_rdata(rdata), .o_exc_take(exc_take),
    .o_eret_take(eret_take), .o_target(target), .o_status(status),
    .o_cause(cause)
  );

  typedef struct {
    logic        mtc0, mfc0, eret, unk, ovf;
    logic [4:0]  addr;
    logic [31:0] wdata, pc;
    logic [4:0]  irq;
    logic [31:0] e_rdata;     // pre-edge combinational outputs
    logic        e_exc, e_eret;
    logic [31:0] e_target;
    logic [31:0] e_status;    // post-edge register state
    logic [31:0] e_cause;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic m_t, logic m_f, logic e, logic u, logic o,
                              logic [4:0] a, logic [31:0] w, logic [31:0] p,
                              logic [4:0] ir, logic [31:0] er, logic ex,
                              logic ee, logic [31:0] et, logic [31:0] es,
                              logic [31:0] ec);
    vec_t v;
    v.mtc0 = m_t; v.mfc0 = m_f; v.eret = e; v.unk = u; v.ovf = o;
    v.addr = a; v.wdata = w; v.pc = p; v.irq = ir;
    v.e_rdata = er; v.e_exc = ex; v.e_eret = ee; v.e_target = et;
    v.e_status = es; v.e_cause = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m_t, input logic m_f, input logic e,
                       input logic u, input logic o, input logic [4:0] a,
                       input logic [31:0] w, input logic [31:0] p,
                       input logic [4:0] ir);
    mtc0 = m_t; mfc0 = m_f; eret = e; unk = u; ovf = o;
    addr = a; wdata = w; pc = p; irq_in = ir;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] VEC = 32'h8000_0180;

  initial begin
    rst = 1'b1;
    idle();
    #2;
    check("reset_status", status, 32'h0);
    check("reset_cause", cause, 32'h0);
    check("reset_target", target, 32'h0);
    check("reset_exc", {31'h0, exc_take}, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    //              mt f  er u  o  addr   wdata          pc            int    rdata         exc eret target        status        cause
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        5'd0, 32'h0,         0, 0, 32'h0,         32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5'd12, 32'h0000_0401, 32'h0,        5'd0, 32'h0,         0, 0, 32'h0,         32'h401,      32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        5'd1, 32'h0,         0, 0, 32'h0,         32'h401,      32'h400));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h100,      5'd1, 32'h0,         1, 0, VEC,           32'h403,      32'h400));
    vecs.push_back(mk(0, 1, 0, 0, 0, 5'd14, 32'h0,         32'h0,        5'd0, 32'h100,       0, 0, 32'h0,         32'h403,      32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5'd0,  32'h0,         32'h104,      5'd0, 32'h0,         0, 1, 32'h100,       32'h401,      32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5'd12, 32'h0,         32'h0,        5'd0, 32'h0,         0, 0, 32'h0,         32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 5'd0,  32'h0,         32'h40,       5'd0, 32'h0,         1, 0, VEC,           32'h2,        32'h28));
    vecs.push_back(mk(0, 1, 0, 0, 0, 5'd14, 32'h0,         32'h0,        5'd0, 32'h40,        0, 0, 32'h0,         32'h2,        32'h28));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5'd0,  32'h0,         32'h200,      5'd0, 32'h0,         1, 0, VEC,           32'h2,        32'h30));
    vecs.push_back(mk(0, 1, 0, 0, 0, 5'd14, 32'h0,         32'h0,        5'd0, 32'h40,        0, 0, 32'h0,         32'h2,        32'h30));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5'd0,  32'h0,         32'h0,        5'd0, 32'h0,         0, 1, 32'h40,        32'h0,        32'h30));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5'd14, 32'hDEAD_BEEF, 32'h300,      5'd0, 32'h0,         1, 0, VEC,           32'h2,        32'h30));
    vecs.push_back(mk(0, 1, 0, 0, 0, 5'd14, 32'h0,         32'h0,        5'd0, 32'h300,       0, 0, 32'h0,         32'h2,        32'h30));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5'd13, 32'hFFFF_FFFF, 32'h0,        5'd0, 32'h0,         0, 0, 32'h0,         32'h2,        32'h330));
    vecs.push_back(mk(1, 1, 0, 0, 0, 5'd5,  32'hFFFF_FFFF, 32'h0,        5'd0, 32'h0,         0, 0, 32'h0,         32'h2,        32'h330));
    vecs.push_back(mk(0, 1, 0, 0, 0, 5'd12, 32'h0,         32'h0,        5'd0, 32'h2,         0, 0, 32'h0,         32'h2,        32'h330));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd13, 32'h0,         32'h0,        5'd0, 32'h330,       0, 1, 32'h300,       32'h0,        32'h330));
    vecs.push_back(mk(0, 0, 1, 1, 0, 5'd0,  32'h0,         32'h500,      5'd0, 32'h0,         1, 0, VEC,           32'h2,        32'h328));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5'd0,  32'h0,         32'h0,        5'd0, 32'h0,         0, 1, 32'h500,       32'h0,        32'h328));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5'd0,  32'h0,         32'h0,        5'd0, 32'h0,         0, 1, 32'h500,       32'h0,        32'h328));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5'd12, 32'h0000_0101, 32'h0,        5'd0, 32'h0,         0, 0, 32'h0,         32'h101,      32'h328));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h600,      5'd0, 32'h0,         1, 0, VEC,           32'h103,      32'h300));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5'd13, 32'h0,         32'h0,        5'd0, 32'h0,         0, 0, 32'h0,         32'h103,      32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5'd0,  32'h0,         32'h0,        5'd0, 32'h0,         0, 1, 32'h600,       32'h101,      32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        5'd0, 32'h0,         0, 0, 32'h0,         32'h101,      32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5'd12, 32'h0,         32'h0,        5'd0, 32'h0,         0, 0, 32'h0,         32'h0,        32'h0));

    foreach (vecs[i]) begin
      drive(vecs[i].mtc0, vecs[i].mfc0, vecs[i].eret, vecs[i].unk, vecs[i].ovf,
            vecs[i].addr, vecs[i].wdata, vecs[i].pc, vecs[i].irq);
      #1;
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
      check($sformatf("v%0d_exc", i), {31'h0, exc_take}, {31'h0, vecs[i].e_exc});
      check($sformatf("v%0d_eret", i), {31'h0, eret_take}, {31'h0, vecs[i].e_eret});
      check($sformatf("v%0d_target", i), target, vecs[i].e_target);
      tick();
      check($sformatf("v%0d_status", i), status, vecs[i].e_status);
      check($sformatf("v%0d_cause", i), cause, vecs[i].e_cause);
    end

    // Timer: Compare=5, Count=3 -> IP[7] after the fourth edge.
    drive(1, 0, 0, 0, 0, 5'd11, 32'd5, 32'h0, 5'd0); tick();
    drive(1, 0, 0, 0, 0, 5'd9,  32'd3, 32'h0, 5'd0); tick();
    idle();
    tick(); tick(); tick();
    check("timer_before", {31'h0, cause[15]}, 32'h0);
    tick();
    check("timer_set", {31'h0, cause[15]}, 32'h1);
    drive(1, 0, 0, 0, 0, 5'd11, 32'd100, 32'h0, 5'd0); tick();
    check("timer_clear", {31'h0, cause[15]}, 32'h0);

    // Timer hit and Compare write on the same edge -> flag stays clear.
    drive(1, 0, 0, 0, 0, 5'd11, 32'd5, 32'h0, 5'd0); tick();
    drive(1, 0, 0, 0, 0, 5'd9,  32'd4, 32'h0, 5'd0); tick();
    idle(); tick();
    drive(1, 0, 0, 0, 0, 5'd11, 32'd5, 32'h0, 5'd0); tick();
    check("timer_set_clear", {31'h0, cause[15]}, 32'h0);
    drive(0, 1, 0, 0, 0, 5'd9, 32'h0, 32'h0, 5'd0); #1;
    check("count_after_hit", rdata, 32'd5);
    tick();

    // Count wrap: MFC0 returns the pre-edge value.
    drive(1, 0, 0, 0, 0, 5'd9, 32'hFFFF_FFFF, 32'h0, 5'd0); tick();
    drive(0, 1, 0, 0, 0, 5'd9, 32'h0, 32'h0, 5'd0); #1;
    check("wrap_pre1", rdata, 32'hFFFF_FFFF);
    tick();
    check("wrap_pre2", rdata, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", rdata, 32'h0);

    // Set up state, then reset in the middle of a cycle carrying an MTC0.
    drive(1, 0, 0, 0, 0, 5'd12, 32'h0000_0401, 32'h0, 5'd1); tick();
    drive(1, 0, 0, 0, 0, 5'd14, 32'h0000_1234, 32'h0, 5'd1); tick();
    drive(1, 0, 0, 0, 0, 5'd11, 32'h0000_0077, 32'h0, 5'd1);
    #2;
    rst = 1'b1;
    #1;
    idle();
    #1;
    check("rst_status", status, 32'h0);
    check("rst_cause", cause, 32'h0);
    check("rst_exc", {31'h0, exc_take}, 32'h0);
    mfc0 = 1'b1;
    addr = 5'd9;  #1; check("rst_count", rdata, 32'h0);
    addr = 5'd11; #1; check("rst_compare", rdata, 32'h0);
    addr = 5'd14; #1; check("rst_epc", rdata, 32'h0);
    tick();
    rst = 1'b0;
    addr = 5'd9;
    tick();
    check("post_rst_edge1", rdata, 32'h0);
    tick();
    check("post_rst_edge2", rdata, 32'h1);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
